// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
// Purpose: shared types and constants for the SRAM arbiter slice.
//   master_e    - master identifier stored in the route FIFO (0 = inst, 1 = data)
//   arb_state_e - arbitration FSM state encoding
//   SIZE_WORD   - transfer size the instruction master always uses
package sram_arbiter_pkg;

  typedef enum logic {
    MST_INST = 1'b0,
    MST_DATA = 1'b1
  } master_e;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
// Purpose: bundles every bus signal around the arbiter.
//   inst_*  - instruction master (read-only, word sized)
//   data_*  - data master request/response
//   ram_*   - shared slave request/response (in-order responses)
//   err_orphan - sticky flag raised by a response with nothing outstanding
// Modports:
//   slave  - the arbiter's view (receives both masters, drives the RAM side)
//   master - the environment's view (drives masters and the RAM response)
interface sram_arbiter_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic        ram_req;
  logic        ram_wr;
  logic [1:0]  ram_size;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_addr_ok;
  logic        ram_data_ok;

  logic        err_orphan;

  modport slave (
    input  inst_req, inst_addr,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output ram_req, ram_wr, ram_size, ram_addr, ram_wdata,
    input  ram_rdata, ram_addr_ok, ram_data_ok,
    output err_orphan
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  ram_req, ram_wr, ram_size, ram_addr, ram_wdata,
    output ram_rdata, ram_addr_ok, ram_data_ok,
    input  err_orphan
  );

endinterface

// File: rtl/sram_arbiter_route_fifo.sv
// route_fifo
// Purpose: remembers which master owns each outstanding RAM request so that
// in-order responses can be steered back to the right master.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - enqueue one master ID (ignored while full)
//   pop,  dout  - dequeue the head; dout shows the current head
//   full, empty - occupancy flags (full when DEPTH entries are held)
module route_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the AW-bit pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Purpose: shares one in-order SRAM-like slave between an instruction master
// and a data master with zero added latency. Requests are muxed
// combinationally, and responses are steered back using a FIFO of master IDs.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - sram_arbiter_if.slave carrying inst_*, data_*, ram_*, err_orphan
// Parameter:
//   DEPTH      - maximum number of accepted but unanswered requests
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  sram_arbiter_if.slave  bus
);

  localparam logic [1:0] ARB    = ST_ARB;
  localparam logic [1:0] LOCK_I = ST_LOCK_I;
  localparam logic [1:0] LOCK_D = ST_LOCK_D;

  logic [1:0] state;
  logic [1:0] state_nxt;
  master_e    last_grant;
  master_e    gnt;
  logic       req_g;
  logic       handshake;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_head;
  logic       pop;
  logic       err_orphan_q;

  // A lock keeps the grant while the slave stalls; in ARB the master that
  // lost the last accepted handshake wins a tie.
  always_comb begin
    gnt = MST_INST;
    case (state)
      LOCK_I: gnt = MST_INST;
      LOCK_D: gnt = MST_DATA;
      default: begin
        if (bus.inst_req && bus.data_req)
          gnt = (last_grant == MST_INST) ? MST_DATA : MST_INST;
        else if (bus.data_req)
          gnt = MST_DATA;
        else
          gnt = MST_INST;
      end
    endcase
  end

  assign req_g     = (gnt == MST_DATA) ? bus.data_req : bus.inst_req;
  // A full route FIFO blocks new requests even if a response pops this cycle.
  assign bus.ram_req = rst_n && !fifo_full && req_g;
  assign handshake = bus.ram_req && bus.ram_addr_ok;

  assign bus.ram_wr    = (gnt == MST_DATA) ? bus.data_wr    : 1'b0;
  assign bus.ram_size  = (gnt == MST_DATA) ? bus.data_size  : SIZE_WORD;
  assign bus.ram_addr  = (gnt == MST_DATA) ? bus.data_addr  : bus.inst_addr;
  assign bus.ram_wdata = (gnt == MST_DATA) ? bus.data_wdata : 32'd0;

  assign bus.inst_addr_ok = handshake && (gnt == MST_INST);
  assign bus.data_addr_ok = handshake && (gnt == MST_DATA);

  // Responses arrive in request order, so the FIFO head names their owner.
  assign pop = rst_n && bus.ram_data_ok && !fifo_empty;
  assign bus.inst_data_ok = pop && !fifo_head;
  assign bus.data_data_ok = pop && fifo_head;
  assign bus.inst_rdata   = bus.inst_data_ok ? bus.ram_rdata : 32'd0;
  assign bus.data_rdata   = bus.data_data_ok ? bus.ram_rdata : 32'd0;
  assign bus.err_orphan   = err_orphan_q;

  route_fifo #(.DEPTH(DEPTH)) u_route_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (handshake),
    .din   (gnt == MST_DATA),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Lock on a stalled request; release on acceptance or when req drops.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB: begin
        if (req_g && !handshake)
          state_nxt = (gnt == MST_DATA) ? LOCK_D : LOCK_I;
      end
      LOCK_I, LOCK_D: begin
        if (!req_g || handshake)
          state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB;
      last_grant   <= MST_INST;
      err_orphan_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (handshake)
        last_grant <= gnt;
      if (bus.ram_data_ok && fifo_empty)
        err_orphan_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Purpose: self-checking bench for sram_arbiter. Inputs change 1 ns after the
// rising edge and outputs are compared at the falling edge. A table covers
// round-robin contention, hand-written sequences cover stalls, a full FIFO,
// orphan responses and reset, and a random phase is compared to a queue-based
// reference model.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   assertCount = 0;
  int   failCount   = 0;

  sram_arbiter_if bus ();

  sram_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ireq, dreq, raok, rdok;
    logic eIaok, eDaok, eIdok, eDdok, eRreq;
    logic [31:0] eAddr;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic setInputs(input logic ireq, input logic [31:0] iaddr,
                           input logic dreq, input logic dwr, input logic [1:0] dsize,
                           input logic [31:0] daddr, input logic [31:0] dwdata,
                           input logic raok, input logic rdok, input logic [31:0] rrdata);
    bus.inst_req    = ireq;
    bus.inst_addr   = iaddr;
    bus.data_req    = dreq;
    bus.data_wr     = dwr;
    bus.data_size   = dsize;
    bus.data_addr   = daddr;
    bus.data_wdata  = dwdata;
    bus.ram_addr_ok = raok;
    bus.ram_data_ok = rdok;
    bus.ram_rdata   = rrdata;
  endtask

  // One cycle: drive just after the edge, return at the falling edge.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwr, input logic [1:0] dsize,
                               input logic [31:0] daddr, input logic [31:0] dwdata,
                               input logic raok, input logic rdok, input logic [31:0] rrdata);
    @(posedge clk);
    #1;
    setInputs(ireq, iaddr, dreq, dwr, dsize, daddr, dwdata, raok, rdok, rrdata);
    #4;
  endtask

  task automatic checkResponses(input string tag, input logic eIaok, input logic eDaok,
                                input logic eIdok, input logic eDdok, input logic [31:0] rdata);
    checkOutput({tag, ".inst_addr_ok"}, 32'(bus.inst_addr_ok), 32'(eIaok));
    checkOutput({tag, ".data_addr_ok"}, 32'(bus.data_addr_ok), 32'(eDaok));
    checkOutput({tag, ".inst_data_ok"}, 32'(bus.inst_data_ok), 32'(eIdok));
    checkOutput({tag, ".data_data_ok"}, 32'(bus.data_data_ok), 32'(eDdok));
    checkOutput({tag, ".inst_rdata"}, bus.inst_rdata, eIdok ? rdata : 32'd0);
    checkOutput({tag, ".data_rdata"}, bus.data_rdata, eDdok ? rdata : 32'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkResponses("reset", 0, 0, 0, 0, 0);
    checkOutput("reset.ram_req", 32'(bus.ram_req), 0);
    checkOutput("reset.err_orphan", 32'(bus.err_orphan), 0);
    rst_n = 1'b1;
  endtask

  // Reference model: ownership queue, lock owner (-1 = none) and last winner.
  task automatic randomPhase(input int cycles);
    int lockOwner = -1;
    int lastG = 0;
    int q[$];
    bit orphan = 0;
    for (int n = 0; n < cycles; n++) begin
      logic ireq, dreq, dwr, raok, rdok;
      logic [1:0] dsize;
      logic [31:0] iaddr, daddr, dwdata, rrdata;
      int g, head;
      bit reqG, rreq, hs, popNow, full;
      ireq = ($urandom_range(0, 99) < 60);
      dreq = ($urandom_range(0, 99) < 60);
      dwr  = 1'($urandom);
      dsize = 2'($urandom);
      iaddr = $urandom; daddr = $urandom; dwdata = $urandom; rrdata = $urandom;
      raok = ($urandom_range(0, 99) < 50);
      rdok = ($urandom_range(0, 99) < 35);
      applyStimulus(ireq, iaddr, dreq, dwr, dsize, daddr, dwdata, raok, rdok, rrdata);

      if (lockOwner >= 0)   g = lockOwner;
      else if (ireq && dreq) g = 1 - lastG;
      else if (dreq)        g = 1;
      else if (ireq)        g = 0;
      else                  g = -1;
      full   = (q.size() == DEPTH);
      reqG   = (g == 0 && ireq) || (g == 1 && dreq);
      rreq   = reqG && !full;
      hs     = rreq && raok;
      popNow = rdok && (q.size() > 0);
      head   = popNow ? q[0] : -1;

      checkResponses("rand", hs && g == 0, hs && g == 1, head == 0, head == 1, rrdata);
      checkOutput("rand.ram_req", 32'(bus.ram_req), 32'(rreq));
      checkOutput("rand.err_orphan", 32'(bus.err_orphan), 32'(orphan));
      if (rreq) begin
        checkOutput("rand.ram_addr", bus.ram_addr, (g == 1) ? daddr : iaddr);
        checkOutput("rand.ram_wr", 32'(bus.ram_wr), (g == 1) ? 32'(dwr) : 0);
        checkOutput("rand.ram_size", 32'(bus.ram_size), (g == 1) ? 32'(dsize) : 32'd2);
        checkOutput("rand.ram_wdata", bus.ram_wdata, (g == 1) ? dwdata : 0);
      end

      if (rdok && q.size() == 0) orphan = 1;
      if (popNow) void'(q.pop_front());
      if (hs) begin
        q.push_back(g);
        lastG = g;
      end
      if (lockOwner < 0) begin
        if (reqG && !hs) lockOwner = g;
      end else if (!reqG || hs) begin
        lockOwner = -1;
      end
    end
  endtask

  initial begin
    vec_t tbl[5];
    logic [31:0] rd;

    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    doReset();

    // Inst read alone, response three cycles later.
    applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
    checkResponses("s1.c0", 1, 0, 0, 0, 0);
    checkOutput("s1.ram_addr", bus.ram_addr, 32'h100);
    checkOutput("s1.ram_size", 32'(bus.ram_size), 32'd2);
    checkOutput("s1.ram_wr", 32'(bus.ram_wr), 0);
    checkOutput("s1.ram_wdata", bus.ram_wdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkResponses("s1.c1", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkResponses("s1.c2", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    checkResponses("s1.c3", 0, 0, 1, 0, 32'h1234_5678);

    // Contention with slave always ready: D,I,D,I grants and responses.
    doReset();
    tbl[0] = '{1, 1, 1, 0, 0, 1, 0, 0, 1, 32'h2000};
    tbl[1] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 32'h1001};
    tbl[2] = '{1, 1, 1, 1, 0, 1, 1, 0, 1, 32'h2002};
    tbl[3] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 32'h1003};
    tbl[4] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      rd = $urandom;
      applyStimulus(tbl[i].ireq, 32'h1000 + i, tbl[i].dreq, 0, 2'b10, 32'h2000 + i, 0,
                    tbl[i].raok, tbl[i].rdok, rd);
      checkResponses($sformatf("rr[%0d]", i), tbl[i].eIaok, tbl[i].eDaok, tbl[i].eIdok, tbl[i].eDdok, rd);
      checkOutput($sformatf("rr[%0d].ram_req", i), 32'(bus.ram_req), 32'(tbl[i].eRreq));
      if (tbl[i].eRreq) checkOutput($sformatf("rr[%0d].ram_addr", i), bus.ram_addr, tbl[i].eAddr);
    end

    // Data write stalls two cycles; its lock holds off inst even though inst
    // would win the round-robin.
    doReset();
    applyStimulus(0, 0, 1, 0, 2'b10, 32'h10, 0, 1, 0, 0);
    checkResponses("s3.pre", 0, 1, 0, 0, 0);
    applyStimulus(0, 32'h200, 1, 1, 2'b10, 32'h20, 32'hDEAD_BEEF, 0, 0, 0);
    checkResponses("s3.c0", 0, 0, 0, 0, 0);
    checkOutput("s3.c0.ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    applyStimulus(1, 32'h200, 1, 1, 2'b10, 32'h20, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("s3.c1.ram_addr", bus.ram_addr, 32'h20);
    checkOutput("s3.c1.ram_wr", 32'(bus.ram_wr), 1);
    applyStimulus(1, 32'h200, 1, 1, 2'b10, 32'h20, 32'hDEAD_BEEF, 1, 0, 0);
    checkResponses("s3.c2", 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0);
    checkResponses("s3.c3", 1, 0, 0, 0, 0);
    checkOutput("s3.c3.ram_addr", bus.ram_addr, 32'h200);

    // Fill the FIFO, then a fifth request waits for the first response.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, 0, 1, 0, 2'b10, 32'h40 + 4 * i, 0, 1, 0, 0);
      checkResponses($sformatf("s4.fill%0d", i), 0, 1, 0, 0, 0);
    end
    applyStimulus(0, 0, 1, 0, 2'b10, 32'h80, 0, 1, 0, 0);
    checkResponses("s4.full", 0, 0, 0, 0, 0);
    checkOutput("s4.full.ram_req", 32'(bus.ram_req), 0);
    applyStimulus(0, 0, 1, 0, 2'b10, 32'h80, 0, 1, 1, 32'hA5A5_0001);
    checkResponses("s4.pop", 0, 0, 0, 1, 32'hA5A5_0001);
    checkOutput("s4.pop.ram_req", 32'(bus.ram_req), 0);
    applyStimulus(0, 0, 1, 0, 2'b10, 32'h80, 0, 1, 0, 0);
    checkResponses("s4.after", 0, 1, 0, 0, 0);

    // Orphan response sets the sticky flag; reset clears it at once.
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    checkResponses("s5.c0", 0, 0, 0, 0, 0);
    checkOutput("s5.c0.err_orphan", 32'(bus.err_orphan), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s5.c1.err_orphan", 32'(bus.err_orphan), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s5.c2.err_orphan", 32'(bus.err_orphan), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("s5.rst.err_orphan", 32'(bus.err_orphan), 0);

    // Reset with two requests outstanding and inputs still active.
    doReset();
    applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 32'h304, 0, 0, 0, 0, 0, 1, 0, 0);
    checkResponses("s6.pre", 1, 0, 0, 0, 0);
    applyStimulus(1, 32'h308, 1, 0, 2'b10, 32'h30C, 0, 1, 1, 32'h5555_AAAA);
    rst_n = 1'b0;
    #1;
    checkResponses("s6.rst", 0, 0, 0, 0, 0);
    checkOutput("s6.rst.ram_req", 32'(bus.ram_req), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    setInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
    checkResponses("s6.after", 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s6.after.err_orphan", 32'(bus.err_orphan), 1);

    // Randomized traffic against the reference model.
    doReset();
    randomPhase(400);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
